// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF)
// and the data side. Each access is arbitrated in IDLE, issued in ACCESS
// until mem_ack or the watchdog expires, and acknowledged in DONE.
// Optional build macro MEM_ARB_RR_EN: simultaneous requests alternate
// winners instead of always favouring the data side.
module mem_port_arbiter #(
    parameter int DP_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [DP_WIDTH-1:0] i_addr,
    output logic                i_ack,
    output logic [DP_WIDTH-1:0] i_rdata,
    input  logic                d_req,
    input  logic [3:0]          d_we,
    input  logic [DP_WIDTH-1:0] d_addr,
    input  logic [DP_WIDTH-1:0] d_wdata,
    output logic                d_ack,
    output logic [DP_WIDTH-1:0] d_rdata,
    output logic [DP_WIDTH-1:0] mem_addr,
    output logic [DP_WIDTH-1:0] mem_wdata,
    output logic                mem_re,
    output logic [3:0]          mem_we,
    input  logic                mem_ack,
    input  logic [DP_WIDTH-1:0] mem_rdata,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic                OWN_DATA = 1'b0;
    localparam logic                OWN_IF   = 1'b1;
    localparam logic [7:0]          CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [DP_WIDTH-1:0] ERR_WORD = DP_WIDTH'(32'hDEADBEEF);

    state_t              state;
    state_t              state_nxt;
    logic                owner;
    logic [DP_WIDTH-1:0] iss_addr;
    logic [DP_WIDTH-1:0] iss_wdata;
    logic [3:0]          iss_we;
    logic [7:0]          wait_cnt;
    logic                aborted;
    logic                any_req;
    logic                grant_data;
    logic                expire;

    assign any_req = i_req || d_req;

`ifdef MEM_ARB_RR_EN
    logic last_win;

    // A tie goes to the side that did not win the previous grant.
    assign grant_data = d_req && (!i_req || (last_win == OWN_IF));

    // Record the winner of every grant; starting at IF makes the first tie go to DATA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_win <= OWN_IF;
        else if (state == IDLE && any_req)
            last_win <= grant_data ? OWN_DATA : OWN_IF;
    end
`else
    // Data always wins a tie: it belongs to the older instruction.
    assign grant_data = d_req;
`endif

    // Watchdog fires on the last allowed ACCESS cycle; a coincident mem_ack wins.
    assign expire = (state == ACCESS) && (wait_cnt == CNT_LAST) && !mem_ack;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and per-state outputs; memory side is idle outside ACCESS.
    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_re      = 1'b0;
        mem_we      = 4'b0000;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_addr  = iss_addr;
                mem_wdata = iss_wdata;
                mem_re    = (iss_we == 4'b0000);
                mem_we    = iss_we;
                if (mem_ack || expire)
                    state_nxt = DONE;
            end
            DONE: begin
                i_ack       = (owner == OWN_IF);
                d_ack       = (owner == OWN_DATA);
                timeout_err = aborted;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request, count wait cycles, capture the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWN_DATA;
            iss_addr  <= '0;
            iss_wdata <= '0;
            iss_we    <= 4'b0000;
            wait_cnt  <= 8'd0;
            aborted   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_data ? OWN_DATA : OWN_IF;
                        iss_addr  <= grant_data ? d_addr : i_addr;
                        iss_wdata <= grant_data ? d_wdata : '0;
                        iss_we    <= grant_data ? d_we : 4'b0000;
                        wait_cnt  <= 8'd0;
                        aborted   <= 1'b0;
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (mem_ack) begin
                        if (owner == OWN_IF)
                            i_rdata <= mem_rdata;
                        else
                            d_rdata <= mem_rdata;
                    end else if (expire) begin
                        aborted <= 1'b1;
                        if (owner == OWN_IF)
                            i_rdata <= ERR_WORD;
                        else
                            d_rdata <= ERR_WORD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with a short watchdog (TIMEOUT_CYCLES=4).
// Table of single transactions plus hand sequences for reset abort and ties.
module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_req = 1'b0;
    logic [W-1:0] i_addr = '0;
    logic         i_ack;
    logic [W-1:0] i_rdata;
    logic         d_req = 1'b0;
    logic [3:0]   d_we = 4'b0000;
    logic [W-1:0] d_addr = '0;
    logic [W-1:0] d_wdata = '0;
    logic         d_ack;
    logic [W-1:0] d_rdata;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_re;
    logic [3:0]   mem_we;
    logic         mem_ack = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         is_data;
        logic [3:0]   we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        int           delay;   // ACCESS cycle carrying mem_ack, 0 = never
        logic [W-1:0] rdata;
    } vec_t;

    typedef struct {
        logic         is_data;
        logic [W-1:0] rdata;
        logic         to;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter #(.DP_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every ack pops the oldest expected completion.
    always @(negedge clk) begin
        if (i_ack || d_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, i_ack, d_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_side", {30'd0, i_ack, d_ack}, e.is_data ? 32'd1 : 32'd2);
                check("ack_rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
                check("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
            end
        end
    end

    task automatic run_txn(input vec_t v);
        exp_t e;
        logic [W-1:0] exp_wd;
        @(posedge clk); #1;
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            i_addr = $urandom;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
            d_addr = $urandom; d_wdata = $urandom; d_we = 4'b1111;
        end
        e.is_data = v.is_data;
        e.to      = (v.delay == 0 || v.delay > TO);
        e.rdata   = e.to ? 32'hDEADBEEF : v.rdata;
        sb.push_back(e);
        exp_wd = v.is_data ? v.wdata : '0;
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            mem_ack   = (k == v.delay);
            mem_rdata = (k == v.delay) ? v.rdata : $urandom;
            @(negedge clk);
            if (k == 1) begin
                check("mem_addr", mem_addr, v.addr);
                check("mem_wdata", mem_wdata, exp_wd);
                check("mem_we", {28'd0, mem_we}, {28'd0, v.we});
                check("mem_re", {31'd0, mem_re}, {31'd0, v.we == 4'b0000});
            end
            check("no_early_ack", {31'd0, i_ack | d_ack}, 32'd0);
            if (k == v.delay) break;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("ack_cycle", {31'd0, v.is_data ? d_ack : i_ack}, 32'd1);
        check("done_mem_idle", {31'd0, mem_re | (|mem_we)}, 32'd0);
        @(posedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 4'b0000, 32'h00400000, 32'h0,        2, 32'h8C080004};
        vecs[1] = '{1'b1, 4'b0100, 32'h10010002, 32'h5A5A5A5A, 1, 32'h01020304};
        vecs[2] = '{1'b1, 4'b0000, 32'h10010010, 32'h0,        3, 32'h12345678};
        vecs[3] = '{1'b1, 4'b0000, 32'h10010020, 32'h0,        0, 32'h0};
        vecs[4] = '{1'b0, 4'b0000, 32'h00400004, 32'h0,        4, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 4'b0000, 32'h00400008, 32'h0,        0, 32'h0};
        vecs[6] = '{1'b1, 4'b1111, 32'h10010040, 32'hA5A5F00F, 1, 32'h0BADF00D};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_acks", {29'd0, i_ack, d_ack, timeout_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int n = 0; n < 7; n++)
            run_txn(vecs[n]);

        // Result registers hold after their ack
        @(negedge clk);
        check("i_rdata_hold", i_rdata, 32'hDEADBEEF);
        check("d_rdata_hold", d_rdata, 32'h0BADF00D);

        // Reset in ACCESS drops enables without a clock edge
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h10010080; d_wdata = 32'h11223344;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_we", {28'd0, mem_we}, {28'd0, 4'b0011});
        #2 rst = 1'b0;
        #1;
        check("async_mem_we", {28'd0, mem_we}, 32'd0);
        check("async_mem_re", {31'd0, mem_re}, 32'd0);
        check("async_mem_addr", mem_addr, 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_ack_ignored", {29'd0, i_ack, d_ack, mem_re}, 32'd0);
        end
        check("late_ack_no_capture", d_rdata, 32'd0);
        @(posedge clk);

        // Simultaneous requests held continuously
        begin
            logic         win[4];
            logic [W-1:0] rv[4];
`ifdef MEM_ARB_RR_EN
            win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
            win = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
            rv = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004};
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h10010100; d_wdata = '0;
            i_req = 1'b1; i_addr = 32'h00400100;
            for (int g = 0; g < 4; g++) begin
                exp_t e;
                e.is_data = win[g]; e.rdata = rv[g]; e.to = 1'b0;
                sb.push_back(e);
            end
            for (int g = 0; g < 4; g++) begin
                @(posedge clk); #1;
                mem_ack = 1'b1; mem_rdata = rv[g];
                @(negedge clk);
                check("tie_winner_addr", mem_addr, win[g] ? 32'h10010100 : 32'h00400100);
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (g == 3) begin
                    d_req = 1'b0; i_req = 1'b0;
                end
                @(posedge clk);
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "bench time limit");
    end

endmodule
